range_uart_formatter: RTL and testbench
=======================================

Name: range_uart_formatter

Overview:
Upstream feeder for the UART transmitter in the range-sensor datapath. Accepts one binary range measurement and converts it to fixed-width decimal ASCII with a sequential shift-add-3 (double-dabble) converter. Streams the resulting characters, plus an optional CR/LF terminator, one byte at a time over the transmitter's enable/data/done handshake. Measurements that arrive while a frame is in progress are dropped and counted.

Parameters:
DATA_W, 16, width of the binary measurement input.
DIGITS, 5, number of decimal characters per frame; value sent is meas mod 10^DIGITS, MSD first, leading zeros sent.
ADD_CRLF, 1, 1 = append 0x0D then 0x0A after the digits; 0 = digits only.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
meas_valid  input  1  one-cycle strobe, meas_data valid
meas_data  input  DATA_W  binary range value (unsigned)
busy  output  1  high from capture until frame complete; meas_valid accepted only when low
tx_data  output  8  byte to transmitter, registered, stable from tx_enable until tx_done
tx_enable  output  1  registered one-clock start pulse to transmitter
tx_done  input  1  one-clock pulse from transmitter, byte fully sent (stop bit done)
drop_count  output  8  saturating count of meas_valid strobes seen while busy

Behaviour:
- Clocking/reset: single domain on clk; rst_n is asynchronous and active-low. Reset values: busy=0, tx_enable=0, tx_data=8'h00, drop_count=0, state=IDLE, BCD and shift registers=0.
- States: IDLE, CONVERT, SEND, WAIT_DONE, GAP.
- IDLE: busy=0. On meas_valid=1, capture meas_data, clear the BCD register (DIGITS*4 bits), load the bit counter with DATA_W, and go to CONVERT. busy=1 from the next cycle.
- CONVERT: one bit per clock, MSB first. Each cycle, every BCD nibble >=5 gets +3, then {bcd,shift} is shifted left by 1. Carries out of the top nibble are discarded, which gives mod 10^DIGITS. After exactly DATA_W cycles, go to SEND with char index=0.
- SEND (one cycle): drive tx_data=ASCII(digit[index]) (0x30+nibble) for index<DIGITS, else 0x0D and then 0x0A. Pulse tx_enable=1 for exactly one clock. Go to WAIT_DONE.
- Latency: first tx_enable high in the cycle beginning DATA_W+1 edges after the capture edge.
- WAIT_DONE: tx_enable=0 and tx_data held. Wait indefinitely for tx_done=1, then go to GAP.
- GAP (one cycle, no tx_enable): lets the transmitter leave its cleanup cycle and return to idle before the next start. Then:
  - if more characters remain, index+1 and go to SEND;
  - otherwise go to IDLE; busy=0 in the following cycle.
- Frame length is DIGITS + 2*ADD_CRLF bytes. Inter-byte spacing is transmitter byte time + 2 clocks (GAP + SEND).
- tx_done outside WAIT_DONE: ignored, with no state change.
- meas_valid while busy=1 (including CONVERT and GAP): the measurement is discarded and the current frame is unaffected. drop_count +1, saturating at 255. meas_valid in the same cycle busy falls is accepted.
- Reset mid-frame: all outputs go to reset values immediately and the frame is abandoned. This block does not reset the transmitter; any byte already started completes on the line.
- Width rules: the bit counter is sized for DATA_W; the char index is sized for DIGITS+2. No arithmetic overflow except the intentional top-nibble discard.

Test Plan:
- meas_data=1234, defaults -> tx_data sequence 0x30,0x31,0x32,0x33,0x34,0x0D,0x0A; 7 tx_enable pulses each one clock wide; first pulse 17 clocks after capture; busy falls after 7th tx_done + GAP.
- meas_data=65535 then meas_data=0 (second applied once busy=0) -> 0x36,0x35,0x35,0x33,0x35,0x0D,0x0A, then 0x30 x5,0x0D,0x0A.
- DIGITS=3, ADD_CRLF=0, meas_data=1234 -> 0x32,0x33,0x34 only; busy falls after 3rd tx_done.
- Hold tx_done low 1000 clocks after first tx_enable -> tx_data stays 0x30, no second tx_enable; spurious tx_done pulse during CONVERT of a later frame -> ignored, sequence unchanged.
- Three meas_valid strobes during a busy frame, then 300 more -> frame bytes unchanged; drop_count=3, then saturates at 255.
- Assert rst_n=0 after 2nd tx_done of meas_data=1234 -> busy=0, tx_enable=0, tx_data=0x00, drop_count=0 asynchronously; new meas_data=42 -> full frame 0x30,0x30,0x30,0x34,0x32,0x0D,0x0A.

Source files
------------

// File: rtl/range_uart_formatter.sv
// Binary range measurement to fixed-width decimal ASCII, streamed byte by byte
// to a UART transmitter over an enable/data/done handshake.
module range_uart_formatter #(
  parameter int DATA_W   = 16,
  parameter int DIGITS   = 5,
  parameter int ADD_CRLF = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_meas_valid,
  input  logic [DATA_W-1:0] i_meas_data,
  output logic              o_busy,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_enable,
  input  logic              i_tx_done,
  output logic [7:0]        o_drop_count
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DIGITS + 3);
  localparam logic [IDX_W-1:0] DIG_IDX  = IDX_W'(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS + 2 * ADD_CRLF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONVERT   = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_tx_enable;
  logic [7:0]          r_tx_data;
  logic [7:0]          r_drop;

  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W+DATA_W-1:0] w_cat;
  logic [3:0]              w_nib;
  logic [7:0]              w_char;

  // Add-3 correction of every BCD nibble, then the combined left shift.
  // The bit shifted out of the top nibble is dropped, giving mod 10^DIGITS.
  always_comb begin
    w_bcd_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[k*4 +: 4] >= 4'd5) begin
        w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
      end else begin
        w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4];
      end
    end
    w_cat = {w_bcd_adj, r_shift} << 1;
  end

  // Character for the current index: digits MSD first, then CR, then LF.
  always_comb begin
    w_nib = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      w_nib = (r_idx == IDX_W'(k)) ? r_bcd[(DIGITS-1-k)*4 +: 4] : w_nib;
    end
    if (r_idx < DIG_IDX) begin
      w_char = {4'h3, w_nib};
    end else if (r_idx == DIG_IDX) begin
      w_char = 8'h0D;
    end else begin
      w_char = 8'h0A;
    end
  end

  // Frame sequencer: capture, convert, then one SEND/WAIT_DONE/GAP per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_bitcnt    <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_tx_enable <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_tx_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_meas_valid) begin
            r_shift  <= i_meas_data;
            r_bcd    <= '0;
            r_bitcnt <= CNT_W'(DATA_W);
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CONVERT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_shift} <= w_cat;
          r_bitcnt         <= r_bitcnt - CNT_W'(1);
          if (r_bitcnt == CNT_W'(1)) begin
            r_idx   <= '0;
            r_state <= S_SEND;
          end else begin
            r_state <= S_CONVERT;
          end
        end
        S_SEND: begin
          r_tx_data   <= w_char;
          r_tx_enable <= 1'b1;
          r_state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_done) begin
            r_state <= S_GAP;
          end else begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_GAP: begin
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_SEND;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating count of measurements rejected while a frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 8'h00;
    end else if (i_meas_valid && r_busy && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end else begin
      r_drop <= r_drop;
    end
  end

  assign o_busy       = r_busy;
  assign o_tx_data    = r_tx_data;
  assign o_tx_enable  = r_tx_enable;
  assign o_drop_count = r_drop;

endmodule

// File: tb/tb_range_uart_formatter.sv
// Bench for range_uart_formatter: default instance plus a 3-digit no-CRLF instance,
// both fed the same measurements and served by a simple transmitter model.
module tb_range_uart_formatter;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int         meas;
    logic [7:0] e0 [7];
    logic [7:0] e1 [3];
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        meas_valid0, meas_valid1;
  logic [15:0] meas_data0, meas_data1;
  logic        busy0, busy1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_enable0, tx_enable1;
  logic        tx_done0, tx_done1;
  logic [7:0]  drop_count0, drop_count1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bq_t  got0, got1, q0, q1;
  int   en0[$], en1[$], dn0[$], dn1[$];
  int   tmr0 = 0, tmr1 = 0, byte_time = 4, extra_en = 0;
  bit   hold_done = 1'b0, spur_req = 1'b0;
  int   cap = 0, fall0 = -1, fall1 = -1, m = 0;
  vec_t tbl [5];

  range_uart_formatter dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_meas_valid(meas_valid0), .i_meas_data(meas_data0),
    .o_busy(busy0), .o_tx_data(tx_data0), .o_tx_enable(tx_enable0),
    .i_tx_done(tx_done0), .o_drop_count(drop_count0)
  );

  range_uart_formatter #(.DATA_W(16), .DIGITS(3), .ADD_CRLF(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_meas_valid(meas_valid1), .i_meas_data(meas_data1),
    .o_busy(busy1), .o_tx_data(tx_data1), .o_tx_enable(tx_enable1),
    .i_tx_done(tx_done1), .o_drop_count(drop_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expected frame straight from the decimal definition.
  function automatic bq_t model(input int meas, input int digits, input bit crlf);
    bq_t q;
    int  p = 1;
    int  v;
    for (int i = 0; i < digits; i++) p = p * 10;
    v = meas % p;
    for (int i = 0; i < digits; i++) begin
      p = p / 10;
      q.push_back(8'h30 + 8'((v / p) % 10));
    end
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  // Transmitter model: accepts a byte on tx_enable, answers tx_done byte_time clocks later.
  initial begin
    tx_done0 = 1'b0;
    tx_done1 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done0 = 1'b0;
      tx_done1 = 1'b0;
      if (spur_req) begin
        tx_done0 = 1'b1;
        tx_done1 = 1'b1;
        spur_req = 1'b0;
      end
      if (tmr0 > 0) begin
        if (tx_enable0) extra_en++;
        if (!hold_done) tmr0--;
        if (tmr0 == 0) begin tx_done0 = 1'b1; dn0.push_back(cyc); end
      end else if (tx_enable0) begin
        got0.push_back(tx_data0); en0.push_back(cyc); tmr0 = byte_time;
      end
      if (tmr1 > 0) begin
        if (tx_enable1) extra_en++;
        if (!hold_done) tmr1--;
        if (tmr1 == 0) begin tx_done1 = 1'b1; dn1.push_back(cyc); end
      end else if (tx_enable1) begin
        got1.push_back(tx_data1); en1.push_back(cyc); tmr1 = byte_time;
      end
    end
  end

  task automatic start_frame(input int meas);
    int t = 0;
    while ((busy0 || busy1) && t < 5000) begin @(negedge clk); t++; end
    chk("idle_wait", int'(busy0 | busy1), 0);
    got0.delete(); got1.delete(); en0.delete(); en1.delete(); dn0.delete(); dn1.delete();
    extra_en = 0; fall0 = -1; fall1 = -1;
    meas_valid0 = 1'b1; meas_valid1 = 1'b1;
    meas_data0 = meas[15:0]; meas_data1 = meas[15:0];
    @(negedge clk);
    cap = cyc;
    meas_valid0 = 1'b0; meas_valid1 = 1'b0;
    chk("busy_rise", int'(busy0 & busy1), 1);
  endtask

  task automatic finish_frame();
    int t = 0;
    while ((fall0 < 0 || fall1 < 0) && t < 5000) begin
      @(negedge clk); t++;
      if (!busy0 && fall0 < 0) fall0 = cyc;
      if (!busy1 && fall1 < 0) fall1 = cyc;
    end
    chk("frame_timeout", int'(fall0 < 0 || fall1 < 0), 0);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (dn0.size() < n && t < 3000) begin @(negedge clk); t++; end
    chk("done_wait", int'(dn0.size() >= n), 1);
  endtask

  task automatic check_frame(input string tag, input bq_t e0, input bq_t e1);
    chk({tag, "_len0"}, got0.size(), e0.size());
    for (int i = 0; i < e0.size() && i < got0.size(); i++)
      chk($sformatf("%s_b0_%0d", tag, i), int'(got0[i]), int'(e0[i]));
    chk({tag, "_len1"}, got1.size(), e1.size());
    for (int i = 0; i < e1.size() && i < got1.size(); i++)
      chk($sformatf("%s_b1_%0d", tag, i), int'(got1[i]), int'(e1[i]));
    chk({tag, "_lat0"}, (en0.size() > 0) ? en0[0] - cap : -1, 17);
    chk({tag, "_lat1"}, (en1.size() > 0) ? en1[0] - cap : -1, 17);
    for (int i = 0; i + 1 < en0.size() && i < dn0.size(); i++)
      chk($sformatf("%s_space_%0d", tag, i), en0[i+1] - dn0[i], 3);
    chk({tag, "_fall0"}, fall0 - ((dn0.size() > 0) ? dn0[dn0.size()-1] : 0), 2);
    chk({tag, "_fall1"}, fall1 - ((dn1.size() > 0) ? dn1[dn1.size()-1] : 0), 2);
    chk({tag, "_pulse"}, extra_en, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    meas_valid0 = 1'b0; meas_valid1 = 1'b0;
    meas_data0 = 16'd0; meas_data1 = 16'd0;
    tbl[0] = '{meas: 1234,  e0: '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, e1: '{8'h32, 8'h33, 8'h34}};
    tbl[1] = '{meas: 65535, e0: '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A}, e1: '{8'h35, 8'h33, 8'h35}};
    tbl[2] = '{meas: 0,     e0: '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}, e1: '{8'h30, 8'h30, 8'h30}};
    tbl[3] = '{meas: 42,    e0: '{8'h30, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A}, e1: '{8'h30, 8'h34, 8'h32}};
    tbl[4] = '{meas: 10000, e0: '{8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}, e1: '{8'h30, 8'h30, 8'h30}};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_en", int'(tx_enable0), 0);
    chk("rst_data", int'(tx_data0), 0);
    chk("rst_drop", int'(drop_count0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_drop1", int'(drop_count1), 0);

    for (int i = 0; i < 5; i++) begin
      byte_time = 2 + i;
      start_frame(tbl[i].meas);
      finish_frame();
      q0 = {}; q1 = {};
      for (int j = 0; j < 7; j++) q0.push_back(tbl[i].e0[j]);
      for (int j = 0; j < 3; j++) q1.push_back(tbl[i].e1[j]);
      check_frame($sformatf("vec%0d", i), q0, q1);
    end

    for (int r = 0; r < 20; r++) begin
      byte_time = int'($urandom_range(1, 8));
      m = int'($urandom_range(0, 65535));
      start_frame(m);
      finish_frame();
      check_frame($sformatf("rnd%0d", r), model(m, 5, 1'b1), model(m, 3, 1'b0));
    end

    // Drops in CONVERT, WAIT_DONE and GAP leave the frame intact.
    byte_time = 3;
    start_frame(1234);
    repeat (2) @(negedge clk);
    meas_valid0 = 1'b1; meas_data0 = 16'd7; @(negedge clk); meas_valid0 = 1'b0;
    repeat (20) @(negedge clk);
    meas_valid0 = 1'b1; meas_data0 = 16'd8; @(negedge clk); meas_valid0 = 1'b0;
    wait_done(2);
    if (dn0.size() >= 2) begin
      for (int t = 0; t < 100 && cyc != dn0[1] + 1; t++) @(negedge clk);
    end
    meas_valid0 = 1'b1; meas_data0 = 16'd9; @(negedge clk); meas_valid0 = 1'b0;
    finish_frame();
    check_frame("drop", model(1234, 5, 1'b1), model(1234, 3, 1'b0));
    chk("drop_cnt3", int'(drop_count0), 3);
    chk("drop_cnt_other", int'(drop_count1), 0);

    // Stalled transmitter, with a long burst of rejected strobes meanwhile.
    hold_done = 1'b1;
    start_frame(0);
    repeat (20) @(negedge clk);
    meas_valid0 = 1'b1;
    repeat (300) @(negedge clk);
    meas_valid0 = 1'b0;
    repeat (680) @(negedge clk);
    chk("hold_bytes", got0.size(), 1);
    chk("hold_data", int'(tx_data0), 8'h30);
    chk("hold_busy", int'(busy0), 1);
    chk("hold_en", extra_en, 0);
    chk("drop_sat", int'(drop_count0), 255);
    hold_done = 1'b0;
    finish_frame();
    check_frame("hold", model(0, 5, 1'b1), model(0, 3, 1'b0));
    chk("drop_sat_kept", int'(drop_count0), 255);

    // Stray tx_done during conversion must be ignored.
    byte_time = 2;
    m = int'($urandom_range(0, 65535));
    start_frame(m);
    repeat (4) @(negedge clk);
    spur_req = 1'b1;
    finish_frame();
    check_frame("spur", model(m, 5, 1'b1), model(m, 3, 1'b0));

    // Asynchronous reset mid-frame, then a clean frame.
    byte_time = 4;
    start_frame(1234);
    wait_done(2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_en", int'(tx_enable0), 0);
    chk("mid_rst_data", int'(tx_data0), 0);
    chk("mid_rst_drop", int'(drop_count0), 0);
    chk("mid_rst_busy1", int'(busy1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_frame(42);
    finish_frame();
    q0 = {}; q1 = {};
    for (int j = 0; j < 7; j++) q0.push_back(tbl[3].e0[j]);
    for (int j = 0; j < 3; j++) q1.push_back(tbl[3].e1[j]);
    check_frame("after_rst", q0, q1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
